// File: rtl/cpu_storage_unit.sv
// cpu_storage_unit
// ----------------
// Storage core of the single-cycle RISC-V processor: fixed-program instruction
// ROM, 32x32 register file and a 256-word data RAM behind one clock.
//
// Ports:
//   CLOCK_50      in   clock, all state updates on the rising edge
//   reset         in   synchronous, active-high
//   pc            in   instruction ROM word address
//   instr         out  ROM word at pc (combinational)
//   read_reg1/2   in   register file read indices
//   read_data1/2  out  register contents (combinational, x0 reads 0)
//   write_reg     in   register file write index
//   write_data    in   register file write value
//   write_enable  in   register file write strobe
//   ram_address   in   data RAM word address
//   ram_data      in   data RAM write value
//   ram_wren      in   data RAM write strobe
//   ram_q         out  registered data RAM read value (one-cycle latency)
module cpu_storage_unit #(
  parameter int DATA_W = 32,
  parameter int ROM_AW = 5,
  parameter int RAM_AW = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [ROM_AW-1:0] pc,
  output logic [DATA_W-1:0] instr,
  input  logic [4:0]        read_reg1,
  input  logic [4:0]        read_reg2,
  input  logic [4:0]        write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_enable,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic [RAM_AW-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_data,
  input  logic              ram_wren,
  output logic [DATA_W-1:0] ram_q
);

  localparam int RAM_WORDS = 1 << RAM_AW;

  // ---------------------------------------------------------------------------
  // Instruction ROM: fully decoded, everything past the program is a nop.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_instr;

  always_comb begin
    w_instr = DATA_W'(32'h0000_0013);
    case (pc)
      ROM_AW'(0): w_instr = DATA_W'(32'h0050_0093); // addi x1,x0,5
      ROM_AW'(1): w_instr = DATA_W'(32'h0070_0113); // addi x2,x0,7
      ROM_AW'(2): w_instr = DATA_W'(32'h0020_81B3); // add  x3,x1,x2
      ROM_AW'(3): w_instr = DATA_W'(32'h0030_2223); // sw   x3,4(x0)
      ROM_AW'(4): w_instr = DATA_W'(32'h0040_2203); // lw   x4,4(x0)
      ROM_AW'(5): w_instr = DATA_W'(32'h0031_82B3); // add  x5,x3,x3
      ROM_AW'(6): w_instr = DATA_W'(32'h0050_2423); // sw   x5,8(x0)
      default:    w_instr = DATA_W'(32'h0000_0013); // nop
    endcase
  end

  assign instr = w_instr;

  // ---------------------------------------------------------------------------
  // Register file: asynchronous reads, synchronous write, no write bypass.
  // Entry 0 is never written; the read mux also forces it to zero so x0 stays
  // zero regardless of what the storage holds.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_regs [32];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (write_enable && (write_reg != 5'd0)) begin
      r_regs[write_reg] <= write_data;
    end
  end

  assign read_data1 = (read_reg1 == 5'd0) ? '0 : r_regs[read_reg1];
  assign read_data2 = (read_reg2 == 5'd0) ? '0 : r_regs[read_reg2];

  // ---------------------------------------------------------------------------
  // Data RAM: write port ignores reset so a write coincident with reset still
  // lands; the read register is cleared by reset. Reading and writing the same
  // address on one edge returns the old word (read-first).
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [RAM_WORDS];
  logic [DATA_W-1:0] r_ram_q;

  always_ff @(posedge CLOCK_50) begin
    if (ram_wren) begin
      r_mem[ram_address] <= ram_data;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_ram_q <= '0;
    end else begin
      r_ram_q <= r_mem[ram_address];
    end
  end

  assign ram_q = r_ram_q;

endmodule

// File: tb/tb_cpu_storage_unit.sv
// Directed testbench for cpu_storage_unit: ROM sweep, register file write/read,
// x0 protection, read-during-write on both storages, RAM latency and reset.
module tb_cpu_storage_unit;

  logic        CLOCK_50;
  logic        reset;
  logic [4:0]  pc;
  logic [31:0] instr;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        write_enable;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [7:0]  ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;

  int n_total;
  int n_bad;

  cpu_storage_unit #(
    .DATA_W (32),
    .ROM_AW (5),
    .RAM_AW (8)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .pc           (pc),
    .instr        (instr),
    .read_reg1    (read_reg1),
    .read_reg2    (read_reg2),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .write_enable (write_enable),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .ram_address  (ram_address),
    .ram_data     (ram_data),
    .ram_wren     (ram_wren),
    .ram_q        (ram_q)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s got=0x%08h", tag, got);
    end
  endtask

  // One rising edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic reg_write(input logic [4:0] idx, input logic [31:0] val);
    write_reg    = idx;
    write_data   = val;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic ram_write(input logic [7:0] addr, input logic [31:0] val);
    ram_address = addr;
    ram_data    = val;
    ram_wren    = 1'b1;
    tick();
    ram_wren = 1'b0;
  endtask

  logic [31:0] rom_exp [32];

  initial begin
    n_total = 0;
    n_bad   = 0;

    for (int i = 0; i < 32; i++) rom_exp[i] = 32'h0000_0013;
    rom_exp[0] = 32'h0050_0093;
    rom_exp[1] = 32'h0070_0113;
    rom_exp[2] = 32'h0020_81B3;
    rom_exp[3] = 32'h0030_2223;
    rom_exp[4] = 32'h0040_2203;
    rom_exp[5] = 32'h0031_82B3;
    rom_exp[6] = 32'h0050_2423;

    reset        = 1'b1;
    pc           = '0;
    read_reg1    = '0;
    read_reg2    = '0;
    write_reg    = '0;
    write_data   = '0;
    write_enable = 1'b0;
    ram_address  = '0;
    ram_data     = '0;
    ram_wren     = 1'b0;

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    read_reg1 = 5'd5;
    read_reg2 = 5'd31;
    #1;
    check_val("rst_rd1_x5", read_data1, 32'h0);
    check_val("rst_rd2_x31", read_data2, 32'h0);
    check_val("rst_ram_q", ram_q, 32'h0);

    // ROM sweep
    for (int i = 0; i < 32; i++) begin
      pc = 5'(i);
      #1;
      check_val($sformatf("rom_pc%0d", i), instr, rom_exp[i]);
    end

    // Register write/read and x0 protection
    reg_write(5'd3, 32'h0000_000C);
    read_reg1 = 5'd3;
    #1;
    check_val("reg_x3", read_data1, 32'h0000_000C);
    reg_write(5'd0, 32'hFFFF_FFFF);
    read_reg2 = 5'd0;
    #1;
    check_val("reg_x0_discard", read_data2, 32'h0);
    read_reg2 = 5'd3;
    #1;
    check_val("reg_x3_port2", read_data2, 32'h0000_000C);

    // Register read-during-write: old value before edge, new after
    reg_write(5'd5, 32'h1);
    read_reg1    = 5'd5;
    write_reg    = 5'd5;
    write_data   = 32'h2;
    write_enable = 1'b1;
    #1;
    check_val("reg_rdw_before", read_data1, 32'h1);
    tick();
    write_enable = 1'b0;
    check_val("reg_rdw_after", read_data1, 32'h2);

    // RAM latency: ram_q reports the old word on the write edge, new word one edge later
    ram_write(8'd4, 32'h0);
    ram_write(8'd4, 32'h0000_000C);
    check_val("ram_lat_old", ram_q, 32'h0);
    ram_address = 8'd4;
    tick();
    check_val("ram_lat_new", ram_q, 32'h0000_000C);

    // RAM read-during-write on the same address
    ram_write(8'd8, 32'h11);
    ram_write(8'd8, 32'h22);
    check_val("ram_rdw_old", ram_q, 32'h11);
    tick();
    check_val("ram_rdw_new", ram_q, 32'h22);

    // Reset mid-operation with a pending register write and RAM write
    reg_write(5'd1, 32'd5);
    reg_write(5'd2, 32'd7);
    read_reg1 = 5'd1;
    read_reg2 = 5'd2;
    #1;
    check_val("pre_rst_x1", read_data1, 32'd5);
    check_val("pre_rst_x2", read_data2, 32'd7);
    reset        = 1'b1;
    write_reg    = 5'd1;
    write_data   = 32'd9;
    write_enable = 1'b1;
    ram_address  = 8'd12;
    ram_data     = 32'h33;
    ram_wren     = 1'b1;
    tick();
    reset        = 1'b0;
    write_enable = 1'b0;
    ram_wren     = 1'b0;
    check_val("mid_rst_x1", read_data1, 32'h0);
    check_val("mid_rst_x2", read_data2, 32'h0);
    read_reg1 = 5'd3;
    #1;
    check_val("mid_rst_x3", read_data1, 32'h0);
    check_val("mid_rst_ram_q", ram_q, 32'h0);
    ram_address = 8'd4;
    tick();
    check_val("ram_keep_4", ram_q, 32'h0000_000C);
    ram_address = 8'd8;
    tick();
    check_val("ram_keep_8", ram_q, 32'h22);
    ram_address = 8'd12;
    tick();
    check_val("ram_wr_in_rst", ram_q, 32'h33);

    // Highest RAM address
    ram_write(8'd255, 32'hDEAD_BEEF);
    tick();
    check_val("ram_addr255", ram_q, 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
